// File: rtl/sys_mem_arbiter.sv
// Round-robin arbiter giving NREQ cores and one testbench port access to a single RAM port.
// Define ARB_TIMEOUT_EN to abandon grants that wait longer than TIMEOUT cycles for ram_ready.
module sys_mem_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_ren,
    input  logic [NREQ-1:0]      req_wen,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_store,
    output logic [NREQ-1:0]      req_wait,
    output logic [DW-1:0]        req_load,
    input  logic                 tb_ctrl,
    input  logic                 tb_ren,
    input  logic                 tb_wen,
    input  logic [AW-1:0]        tb_addr,
    input  logic [DW-1:0]        tb_store,
    output logic                 tb_own,
    output logic                 ram_ren,
    output logic                 ram_wen,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_store,
    input  logic [DW-1:0]        ram_load,
    input  logic                 ram_ready,
    input  logic [NREQ-1:0]      core_halt,
    output logic                 sys_halt,
    output logic                 arb_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 1) begin : g_bad_nreq
        $error("sys_mem_arbiter: NREQ must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("sys_mem_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_TB   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            sys_halt_q, sys_halt_d;

    logic [NREQ-1:0] req_any;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic [IW-1:0]   gnt_inc;
    logic            gnt_act;
    logic            gnt_wr;
    logic            gnt_rd;
    logic            tmo;

    assign req_any = req_ren | req_wen;

    // A write wins when a core raises both strobes.
    assign gnt_act = req_any[gnt_q];
    assign gnt_wr  = req_wen[gnt_q];
    assign gnt_rd  = req_ren[gnt_q] & ~req_wen[gnt_q];
    assign gnt_inc = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + 1'b1;

    // First requester at or after rr_ptr_q, wrapping modulo NREQ.
    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!pick_vld && req_any[idx]) begin
                pick     = IW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          arb_err_q, arb_err_d;

    assign tmo = (state_q == S_BUSY) && gnt_act && !ram_ready
                 && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d     = cnt_q;
        arb_err_d = arb_err_q | tmo;
        if (state_q != S_BUSY) begin
            cnt_d = '0;
        end else if (!ram_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            arb_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            arb_err_q <= arb_err_d;
        end
    end

    assign arb_err = arb_err_q;
`else
    assign tmo     = 1'b0;
    assign arb_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        sys_halt_d = sys_halt_q | (&core_halt);
        req_wait   = '1;
        req_load   = '0;
        tb_own     = 1'b0;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = '0;
        ram_store  = '0;

        case (state_q)
            S_IDLE: begin
                if (tb_ctrl) begin
                    state_d = S_TB;
                end else if (pick_vld) begin
                    gnt_d   = pick;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                ram_ren   = gnt_rd;
                ram_wen   = gnt_wr;
                ram_addr  = req_addr[int'(gnt_q)*AW +: AW];
                ram_store = req_store[int'(gnt_q)*DW +: DW];
                req_load  = ram_load;
                // An abort wins over a coincident ready: nothing was asked for, so nothing completes.
                if (!gnt_act) begin
                    state_d = S_IDLE;
                end else if (ram_ready) begin
                    req_wait[gnt_q] = 1'b0;
                    rr_ptr_d        = gnt_inc;
                    state_d         = S_IDLE;
                end else if (tmo) begin
                    req_wait[gnt_q] = 1'b0;
                    req_load        = '0;
                    rr_ptr_d        = gnt_inc;
                    state_d         = S_IDLE;
                end
            end

            S_TB: begin
                tb_own    = 1'b1;
                ram_ren   = tb_ren;
                ram_wen   = tb_wen;
                ram_addr  = tb_addr;
                ram_store = tb_store;
                if (!tb_ctrl) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            sys_halt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            sys_halt_q <= sys_halt_d;
        end
    end

    assign sys_halt = sys_halt_q;

endmodule

// File: tb/tb_sys_mem_arbiter.sv
// Directed self-checking bench for sys_mem_arbiter (NREQ=2, default build without ARB_TIMEOUT_EN).
module tb_sys_mem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [NREQ-1:0]     req_ren = '0;
    logic [NREQ-1:0]     req_wen = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ*DW-1:0]  req_store = '0;
    logic [NREQ-1:0]     req_wait;
    logic [DW-1:0]       req_load;
    logic                tb_ctrl = 1'b0;
    logic                tb_ren = 1'b0;
    logic                tb_wen = 1'b0;
    logic [AW-1:0]       tb_addr = '0;
    logic [DW-1:0]       tb_store = '0;
    logic                tb_own;
    logic                ram_ren;
    logic                ram_wen;
    logic [AW-1:0]       ram_addr;
    logic [DW-1:0]       ram_store;
    logic [DW-1:0]       ram_load;
    logic                ram_ready = 1'b0;
    logic [NREQ-1:0]     core_halt = '0;
    logic                sys_halt;
    logic                arb_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem [0:255];

    sys_mem_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_load(req_load),
        .tb_ctrl(tb_ctrl), .tb_ren(tb_ren), .tb_wen(tb_wen), .tb_addr(tb_addr),
        .tb_store(tb_store), .tb_own(tb_own),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_ready(ram_ready),
        .core_halt(core_halt), .sys_halt(sys_halt), .arb_err(arb_err)
    );

    always #5 CLK = ~CLK;

    // Word-addressed RAM model; writes land on the edge that ends a ready cycle.
    assign ram_load = mem[ram_addr[9:2]];
    always @(posedge CLK) begin
        if (ram_wen && ram_ready) mem[ram_addr[9:2]] <= ram_store;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEAD_BEEF;

        // Reset values
        tick();
        tick();
        check("rst_wait",     64'(req_wait), 64'h3);
        check("rst_tb_own",   64'(tb_own),   64'h0);
        check("rst_sys_halt", 64'(sys_halt), 64'h0);
        check("rst_arb_err",  64'(arb_err),  64'h0);
        check("rst_ram_ren",  64'(ram_ren),  64'h0);
        check("rst_ram_wen",  64'(ram_wen),  64'h0);
        check("rst_ram_addr", 64'(ram_addr), 64'h0);
        RST = 1'b0;
        tick();

        // Core0 read of 0x40, RAM ready three cycles after the strobe
        req_ren = 2'b01;
        req_addr[31:0] = 32'h40;
        #1;
        check("t1_idle_ren", 64'(ram_ren), 64'h0);
        tick();
        check("t1_addr",      64'(ram_addr), 64'h40);
        check("t1_ren",       64'(ram_ren),  64'h1);
        check("t1_wait_busy", 64'(req_wait), 64'h3);
        tick();
        check("t1_wait_c2", 64'(req_wait), 64'h3);
        tick();
        check("t1_wait_c3", 64'(req_wait), 64'h3);
        tick();
        ram_ready = 1'b1;
        #1;
        check("t1_wait_done", 64'(req_wait), 64'h2);
        check("t1_load",      64'(req_load), 64'hDEAD_BEEF);
        tick();
        req_ren = '0;
        ram_ready = 1'b0;
        #1;
        check("t1_idle_after", 64'(req_wait), 64'h3);

        // Both cores requesting continuously from reset, RAM always ready
        RST = 1'b1;
        tick();
        RST = 1'b0;
        req_ren = 2'b11;
        req_addr = {32'h200, 32'h100};
        ram_ready = 1'b1;
        #1;
        check("t2_first_idle", 64'(req_wait), 64'h3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t2_gnt%0d_wait", i), 64'(req_wait), (i % 2 == 0) ? 64'h2 : 64'h1);
            check($sformatf("t2_gnt%0d_addr", i), 64'(ram_addr), (i % 2 == 0) ? 64'h100 : 64'h200);
            tick();
            check($sformatf("t2_bubble%0d_wait", i), 64'(req_wait), 64'h3);
            check($sformatf("t2_bubble%0d_ren", i),  64'(ram_ren),  64'h0);
        end
        req_ren = '0;
        ram_ready = 1'b0;

        // Core1 write with testbench takeover requested mid-transaction
        req_wen = 2'b10;
        req_addr[63:32] = 32'h80;
        req_store[63:32] = 32'h1234;
        tick();
        check("t3_wen",   64'(ram_wen),   64'h1);
        check("t3_ren",   64'(ram_ren),   64'h0);
        check("t3_addr",  64'(ram_addr),  64'h80);
        check("t3_store", 64'(ram_store), 64'h1234);
        tb_ctrl = 1'b1;
        #1;
        check("t3_no_preempt", 64'(tb_own),   64'h0);
        check("t3_wait_busy",  64'(req_wait), 64'h3);
        tick();
        ram_ready = 1'b1;
        #1;
        check("t3_wait_done", 64'(req_wait), 64'h1);
        tick();
        req_wen = '0;
        ram_ready = 1'b0;
        #1;
        check("t3_idle_own", 64'(tb_own), 64'h0);
        tick();
        tb_ren = 1'b1;
        tb_addr = 32'h80;
        ram_ready = 1'b1;
        req_ren = 2'b01;
        req_addr[31:0] = 32'h300;
        #1;
        check("t3_tb_own",  64'(tb_own),   64'h1);
        check("t3_tb_ren",  64'(ram_ren),  64'h1);
        check("t3_tb_addr", 64'(ram_addr), 64'h80);
        check("t3_tb_load", 64'(ram_load), 64'h1234);
        check("t3_tb_wait", 64'(req_wait), 64'h3);
        tb_ctrl = 1'b0;
        tb_ren = 1'b0;
        ram_ready = 1'b0;
        tick();
        check("t3_release_own", 64'(tb_own),  64'h0);
        check("t3_release_ren", 64'(ram_ren), 64'h0);
        tick();
        ram_ready = 1'b1;
        #1;
        check("t3_resume_addr", 64'(ram_addr), 64'h300);
        check("t3_resume_wait", 64'(req_wait), 64'h2);
        tick();
        req_ren = '0;
        ram_ready = 1'b0;

        // Core0 with both strobes high is a write
        req_ren = 2'b01;
        req_wen = 2'b01;
        req_addr[31:0] = 32'h44;
        req_store[31:0] = 32'h55;
        tick();
        check("t4_wen", 64'(ram_wen), 64'h1);
        check("t4_ren", 64'(ram_ren), 64'h0);
        ram_ready = 1'b1;
        #1;
        check("t4_wait_done", 64'(req_wait), 64'h2);
        tick();
        req_ren = '0;
        req_wen = '0;
        ram_ready = 1'b0;

        // Core1 aborts; pointer must stay on core1
        req_ren = 2'b10;
        req_addr[63:32] = 32'h600;
        tick();
        check("t5_ren", 64'(ram_ren), 64'h1);
        req_ren = '0;
        ram_ready = 1'b1;
        #1;
        check("t5_abort_wait", 64'(req_wait), 64'h3);
        tick();
        ram_ready = 1'b0;
        req_ren = 2'b11;
        req_addr[31:0] = 32'h500;
        #1;
        check("t5_abort_idle", 64'(ram_ren), 64'h0);
        tick();
        check("t5_rr_kept", 64'(ram_addr), 64'h600);
        check("t5_rr_wait", 64'(req_wait), 64'h3);

        // Reset while BUSY abandons the transaction and clears the pointer
        RST = 1'b1;
        tick();
        ram_ready = 1'b1;
        #1;
        check("t6_wait",   64'(req_wait), 64'h3);
        check("t6_ren",    64'(ram_ren),  64'h0);
        check("t6_tb_own", 64'(tb_own),   64'h0);
        RST = 1'b0;
        tick();
        check("t6_rr_zero", 64'(ram_addr), 64'h500);
        check("t6_wait0",   64'(req_wait), 64'h2);
        tick();
        req_ren = '0;
        ram_ready = 1'b0;

        // Halt aggregation is registered and sticky
        core_halt = 2'b01;
        tick();
        check("t7_halt_partial", 64'(sys_halt), 64'h0);
        core_halt = 2'b11;
        tick();
        check("t7_halt_all", 64'(sys_halt), 64'h1);
        core_halt = 2'b00;
        tick();
        check("t7_halt_sticky", 64'(sys_halt), 64'h1);

        // Testbench beats a simultaneous core request from IDLE
        req_ren = 2'b01;
        tb_ctrl = 1'b1;
        tick();
        check("t8_tb_prio_own",  64'(tb_own),   64'h1);
        check("t8_tb_prio_wait", 64'(req_wait), 64'h3);
        tb_ctrl = 1'b0;
        req_ren = '0;
        tick();
        check("t8_tb_exit", 64'(tb_own),  64'h0);
        check("t8_arb_err", 64'(arb_err), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
